load_store_unit: RTL and testbench

//  Core-side initiator for the word-addressed data memory. Accepts one load/store per handshake,

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared funct3 codes, access-size decode and LSU state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int         STATE_W  = 3;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Reserved funct3 codes fall through to a word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Little-endian lane extract/extend for loads, lane merge for SB/SH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  size_e       w_size;
  logic        w_signed;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size   = f3_size(i_funct3);
    w_signed = ~i_funct3[2];
    w_byte   = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half   = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    o_rdata = i_rword;
    case (w_size)
      SZ_B:    o_rdata = {{24{w_signed & w_byte[7]}}, w_byte};
      SZ_H:    o_rdata = {{16{w_signed & w_half[15]}}, w_half};
      default: o_rdata = i_rword;
    endcase

    o_merged = i_rword;
    case (w_size)
      SZ_B:    o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      SZ_H:    o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory initiator; SB/SH done as read-modify-write.
//            Optional MISALIGN_TRAP_EN macro enables misalignment errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [2:0]         r_f3;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_merge;
  logic [31:0]        r_rdata;
  logic [31:0]        w_ld_rdata;
  logic [31:0]        w_merged;
  logic               w_misalign;
  logic               w_accept;
  size_e              w_req_size;

  assign w_req_size = f3_size(req_funct3);
  assign w_accept   = req_valid & (r_state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  assign w_misalign = ((w_req_size == SZ_H) & req_addr[0]) |
                      ((w_req_size == SZ_W) & (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= w_misalign;
  end

  assign resp_err = r_err & (r_state == S_RESP);
`else
  assign w_misalign = 1'b0;
  assign resp_err   = 1'b0;
`endif

  lsu_align u_align (
    .i_rword   (mem_rdata),
    .i_wdata   (r_wdata),
    .i_funct3  (r_f3),
    .i_addr_lo (r_addr[1:0]),
    .o_rdata   (w_ld_rdata),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misalign)              w_next = S_RESP;
          else if (!req_we)            w_next = S_LOAD;
          else if (w_req_size == SZ_W) w_next = S_WRITE;
          else                         w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = ~rst & (r_state == S_IDLE);
    mem_read   = (r_state == S_LOAD) | (r_state == S_RMW_RD);
    mem_write  = (r_state == S_WRITE);
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    mem_wdata  = 32'h0;
    if (r_state == S_WRITE)
      mem_wdata = (f3_size(r_f3) == SZ_W) ? r_wdata : r_merge;
  end

  // Request fields, merge word and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_merge <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_misalign) r_rdata <= 32'h0;
          end
        end
        S_LOAD:   r_rdata <= w_ld_rdata;
        S_RMW_RD: r_merge <= w_merged;
        S_WRITE:  r_rdata <= 32'h0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    int sz = ref_size(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    int sz = ref_size(f3);
    logic [31:0] v;
    int sh;
    if (sz == 1) begin
      sh = 8 * int'(a);
      v = (w >> sh) & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      sh = 16 * int'(a[1]);
      v = (w >> sh) & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [1:0] a);
    int sz = ref_size(f3);
    logic [31:0] mask;
    int sh;
    if (sz == 4) return wd;
    sh   = (sz == 1) ? 8 * int'(a) : 16 * int'(a[1]);
    mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // ---------------- transaction driver ----------------
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr, output int rd_at,
                        output int wr_at, output logic both, output logic [31:0] maddr,
                        output logic [31:0] wword, output logic rdy);
    lat = 0; nrd = 0; nwr = 0; rd_at = 0; wr_at = 0; both = 1'b0;
    maddr = 32'hFFFF_FFFF; wword = 32'h0; rdata = 32'hX; err = 1'bX;
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_read)  begin nrd++; if (rd_at == 0) rd_at = i; maddr = mem_addr; end
      if (mem_write) begin nwr++; if (wr_at == 0) wr_at = i; wword = mem_wdata; maddr = mem_addr; end
      if (mem_read && mem_write) both = 1'b1;
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  logic [31:0] o_rd, o_ma, o_ww;
  logic        o_err, o_both, o_rdy;
  int          o_lat, o_nrd, o_nwr, o_rda, o_wra;

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); end
    checks++; if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {resp_valid, resp_err, mem_read, mem_write}); end
    checks++; if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0)
      begin errors++; $display("FAIL reset_data: rdata %h addr %h wdata %h want 0", resp_rdata, mem_addr, mem_wdata); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_idle: got %b want 1", req_ready); end
  endtask

  task automatic test_load_lanes;
    logic [31:0] a_tab [4];
    logic [2:0]  f_tab [4];
    logic [31:0] e_tab [4];
    a_tab = '{32'h13, 32'h12, 32'h10, 32'h11};
    f_tab = '{3'b000, 3'b101, 3'b001, 3'b100};
    e_tab = '{32'hFFFFFF88, 32'h00008899, 32'hFFFFAABB, 32'h000000AA};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f_tab[i], a_tab[i], 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
      checks++; if (o_rd !== e_tab[i]) begin errors++; $display("FAIL load_lane[%0d]: got %h want %h", i, o_rd, e_tab[i]); end
      checks++; if (o_lat !== 2) begin errors++; $display("FAIL load_latency[%0d]: got %0d want 2", i, o_lat); end
      checks++; if (o_nrd !== 1 || o_nwr !== 0 || o_ma !== 32'h10)
        begin errors++; $display("FAIL load_strobes[%0d]: rd %0d wr %0d addr %h want 1 0 10", i, o_nrd, o_nwr, o_ma); end
    end
  endtask

  task automatic test_sb_rmw;
    run_op(1'b1, 3'b000, 32'h11, 32'h12345655, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
    ref_mem[4] = 32'h889955BB;
    checks++; if (o_rda !== 1 || o_wra !== 2 || o_nrd !== 1 || o_nwr !== 1)
      begin errors++; $display("FAIL sb_sequence: rd@%0d wr@%0d want rd@1 wr@2", o_rda, o_wra); end
    checks++; if (o_ww !== 32'h889955BB) begin errors++; $display("FAIL sb_wdata: got %h want 889955BB", o_ww); end
    checks++; if (o_lat !== 3 || o_rd !== 32'h0) begin errors++; $display("FAIL sb_resp: lat %0d rdata %h want 3 0", o_lat, o_rd); end
    run_op(1'b0, 3'b010, 32'h10, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
    checks++; if (o_rd !== 32'h889955BB) begin errors++; $display("FAIL sb_readback: got %h want 889955BB", o_rd); end
  endtask

  task automatic test_back_to_back;
    int ready_low, writes;
    logic [31:0] held;
    ready_low = 0; writes = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (!req_ready) ready_low++;
      if (mem_write) writes++;
    end
    req_valid = 1'b0;
    ref_mem[8] = 32'hDEADBEEF;
    checks++; if (ready_low !== 2) begin errors++; $display("FAIL sw_ready_low: got %0d cycles want 2", ready_low); end
    checks++; if (writes !== 1) begin errors++; $display("FAIL sw_single_accept: got %0d writes want 1", writes); end
    run_op(1'b0, 3'b010, 32'h20, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
    checks++; if (o_rd !== 32'hDEADBEEF || o_rdy !== 1'b1)
      begin errors++; $display("FAIL sw_readback: got %h ready %b want DEADBEEF 1", o_rd, o_rdy); end
    held = o_rd;
    @(negedge clk); @(negedge clk);
    checks++; if (resp_rdata !== held) begin errors++; $display("FAIL rdata_hold: got %h want %h", resp_rdata, held); end
  endtask

  task automatic test_misaligned_word;
    run_op(1'b0, 3'b010, 32'h22, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
`ifdef MISALIGN_TRAP_EN
    checks++; if (o_err !== 1'b1 || o_rd !== 32'h0) begin errors++; $display("FAIL mis_trap: err %b rdata %h want 1 0", o_err, o_rd); end
    checks++; if (o_nrd !== 0 || o_nwr !== 0 || o_lat !== 1)
      begin errors++; $display("FAIL mis_no_access: rd %0d wr %0d lat %0d want 0 0 1", o_nrd, o_nwr, o_lat); end
`else
    checks++; if (o_ma !== 32'h20 || o_rd !== 32'hDEADBEEF)
      begin errors++; $display("FAIL mis_align: addr %h rdata %h want 20 DEADBEEF", o_ma, o_rd); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mis_err: got %b want 0", o_err); end
`endif
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h0000CAFE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0)
      begin errors++; $display("FAIL abort_rmw_ctrl: got %b want 00000", {req_ready, resp_valid, resp_err, mem_read, mem_write}); end
    checks++; if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0)
      begin errors++; $display("FAIL abort_rmw_data: rdata %h addr %h wdata %h want 0", resp_rdata, mem_addr, mem_wdata); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (mem[4] !== ref_mem[4]) begin errors++; $display("FAIL abort_rmw_mem: got %h want %h", mem[4], ref_mem[4]); end
    // Abort a SW while mem_write is high; the word must survive.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h01020304;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_wr_pre: mem_write %b want 1", mem_write); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL abort_wr_drop: mem_write %b want 0", mem_write); end
    @(posedge clk); #1;
    checks++; if (mem[8] !== ref_mem[8]) begin errors++; $display("FAIL abort_wr_mem: got %h want %h", mem[8], ref_mem[8]); end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 3'b010, 32'h10, 32'h0, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
    checks++; if (o_rd !== ref_mem[4] || o_lat !== 2)
      begin errors++; $display("FAIL post_reset_lw: got %h lat %0d want %h 2", o_rd, o_lat, ref_mem[4]); end
  endtask

  task automatic test_random;
    logic        we, mis;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_rd;
    int          idx, sz, exp_lat, exp_rd_n, exp_wr_n;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      wd   = $urandom;
      idx  = int'(addr[7:2]);
      sz   = ref_size(f3);
      mis  = ref_mis(f3, addr[1:0]);
      exp_lat  = mis ? 1 : (!we ? 2 : (sz == 4 ? 2 : 3));
      exp_rd_n = (mis || (we && sz == 4)) ? 0 : 1;
      exp_wr_n = (mis || !we) ? 0 : 1;
      exp_rd   = (mis || we) ? 32'h0 : ref_load(ref_mem[idx], f3, addr[1:0]);
      if (we && !mis) ref_mem[idx] = ref_store(ref_mem[idx], wd, f3, addr[1:0]);
      run_op(we, f3, addr, wd, o_rd, o_err, o_lat, o_nrd, o_nwr, o_rda, o_wra, o_both, o_ma, o_ww, o_rdy);
      checks++; if (o_lat !== exp_lat || o_rd !== exp_rd || o_err !== mis)
        begin errors++; $display("FAIL rand_resp[%0d] we=%b f3=%0d a=%h: lat %0d rd %h err %b want %0d %h %b",
                                 n, we, f3, addr, o_lat, o_rd, o_err, exp_lat, exp_rd, mis); end
      checks++; if (o_nrd !== exp_rd_n || o_nwr !== exp_wr_n || o_both !== 1'b0)
        begin errors++; $display("FAIL rand_strobes[%0d]: rd %0d wr %0d both %b want %0d %0d 0",
                                 n, o_nrd, o_nwr, o_both, exp_rd_n, exp_wr_n); end
      checks++; if (mem[idx] !== ref_mem[idx])
        begin errors++; $display("FAIL rand_mem[%0d] word %0d: got %h want %h", n, idx, mem[idx], ref_mem[idx]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i * 32'h01010101);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 32'h01010101);
    end
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    test_reset;
    test_load_lanes;
    test_sb_rmw;
    test_back_to_back;
    test_misaligned_word;
    test_reset_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
